// File: rtl/sonar_varredura.sv
// Sweep-sonar controller: steps a servo position index through N_POS positions
// and fires one HC-SR04 measurement at each one. The echo width is converted to
// rounded centimetres, echo timeouts are flagged, and every result is tagged with
// the position at which it was taken.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   iniciar       in   level; a rising edge starts a sweep (only while idle)
//   parar         in   level; high aborts to idle on the next clock
//   modo          in   0 = single sweep, 1 = continuous ping-pong sweep
//   echo          in   sensor echo, already synchronised
//   trigger       out  sensor trigger pulse
//   posicao       out  servo position index
//   medida        out  last distance in cm
//   medida_pos    out  position at which medida was taken
//   medida_valida out  1-cycle strobe when medida/medida_pos/erro update
//   erro          out  last measurement timed out (medida = MAX_CM)
//   pronto        out  idle after a completed single sweep
//   db_estado     out  current state code
module sonar_varredura #(
    parameter int unsigned N_POS       = 8,
    parameter int unsigned POS_W       = 3,
    parameter int unsigned DIST_W      = 12,
    parameter int unsigned TRIG_CYCLES = 500,
    parameter int unsigned CYC_PER_CM  = 2941,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_CYC = 1500000,
    parameter int unsigned SETTLE_CYC  = 10000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              parar,
    input  logic              modo,
    input  logic              echo,
    output logic              trigger,
    output logic [POS_W-1:0]  posicao,
    output logic [DIST_W-1:0] medida,
    output logic [POS_W-1:0]  medida_pos,
    output logic              medida_valida,
    output logic              erro,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    // One shared phase counter covers settle, trigger and timeout intervals.
    localparam int unsigned CntMax0 = (SETTLE_CYC > TRIG_CYCLES) ? SETTLE_CYC : TRIG_CYCLES;
    localparam int unsigned CntMax  = (CntMax0 > TIMEOUT_CYC) ? CntMax0 : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CntMax + 1);
    localparam int unsigned SUB_W   = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [CNT_W-1:0]  SettleLast  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TrigLast    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [SUB_W-1:0]  SubLast     = SUB_W'(CYC_PER_CM - 1);
    localparam logic [SUB_W-1:0]  SubHalf     = SUB_W'(CYC_PER_CM / 2);
    localparam logic [DIST_W-1:0] CmMax       = DIST_W'(MAX_CM);
    localparam logic [POS_W-1:0]  PosLast     = POS_W'(N_POS - 1);

    typedef enum logic [3:0] {
        Inicial    = 4'd0,
        Posiciona  = 4'd1,
        Dispara    = 4'd2,
        EsperaEcho = 4'd3,
        Mede       = 4'd4,
        Armazena   = 4'd5,
        Proxima    = 4'd6
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d, sub_inc;
    logic [DIST_W-1:0] cm_q, cm_d, cm_inc;
    logic [POS_W-1:0]  posicao_q, posicao_d;
    logic              sobe_q, sobe_d;
    logic              pronto_q, pronto_d;
    logic              iniciar_q;
    logic [DIST_W-1:0] medida_q;
    logic [POS_W-1:0]  medida_pos_q;
    logic              erro_q;
    logic              guarda, guarda_erro;
    logic              inicio, arredonda;
    logic [DIST_W:0]   soma;
    logic [DIST_W-1:0] medida_arred;

    assign inicio = iniciar & ~iniciar_q;

    // One echo-high clock: advance the sub-cm counter, carry into a saturating cm count.
    always_comb begin
        sub_inc = (sub_q == SubLast) ? '0 : sub_q + SUB_W'(1);
        cm_inc  = cm_q;
        if (sub_q == SubLast && cm_q != CmMax) begin
            cm_inc = cm_q + DIST_W'(1);
        end
    end

    assign arredonda    = (CYC_PER_CM > 1) && (sub_q >= SubHalf);
    assign soma         = {1'b0, cm_q} + (DIST_W + 1)'(arredonda);
    assign medida_arred = (soma > (DIST_W + 1)'(MAX_CM)) ? CmMax : soma[DIST_W-1:0];

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        cm_d        = cm_q;
        posicao_d   = posicao_q;
        sobe_d      = sobe_q;
        pronto_d    = pronto_q;
        guarda      = 1'b0;
        guarda_erro = 1'b0;

        unique case (estado_q)
            Inicial: begin
                cnt_d = '0;
                if (inicio) begin
                    estado_d = Posiciona;
                    pronto_d = 1'b0;
                end
            end
            Posiciona: begin
                if (cnt_q == SettleLast) begin
                    cnt_d    = '0;
                    estado_d = Dispara;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            Dispara: begin
                sub_d = '0;
                cm_d  = '0;
                if (cnt_q == TrigLast) begin
                    cnt_d    = '0;
                    estado_d = EsperaEcho;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EsperaEcho: begin
                if (echo) begin
                    // The rise clock is itself an echo-high clock, so count it.
                    estado_d = Mede;
                    cnt_d    = CNT_W'(1);
                    sub_d    = sub_inc;
                    cm_d     = cm_inc;
                end else if (cnt_q == TimeoutLast) begin
                    estado_d    = Armazena;
                    cnt_d       = '0;
                    guarda      = 1'b1;
                    guarda_erro = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            Mede: begin
                if (!echo) begin
                    estado_d = Armazena;
                    cnt_d    = '0;
                    guarda   = 1'b1;
                end else if (cnt_q == TimeoutLast) begin
                    estado_d    = Armazena;
                    cnt_d       = '0;
                    guarda      = 1'b1;
                    guarda_erro = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sub_d = sub_inc;
                    cm_d  = cm_inc;
                end
            end
            Armazena: begin
                estado_d = Proxima;
            end
            Proxima: begin
                estado_d = Posiciona;
                if (!modo) begin
                    // Single sweep always moves upward from wherever it is.
                    sobe_d = 1'b1;
                    if (posicao_q == PosLast) begin
                        pronto_d = 1'b1;
                        estado_d = Inicial;
                    end else begin
                        posicao_d = posicao_q + POS_W'(1);
                    end
                end else if (sobe_q) begin
                    if (posicao_q == PosLast) begin
                        sobe_d    = 1'b0;
                        posicao_d = posicao_q - POS_W'(1);
                    end else begin
                        posicao_d = posicao_q + POS_W'(1);
                    end
                end else begin
                    if (posicao_q == '0) begin
                        sobe_d    = 1'b1;
                        posicao_d = posicao_q + POS_W'(1);
                    end else begin
                        posicao_d = posicao_q - POS_W'(1);
                    end
                end
            end
            default: begin
                estado_d = Inicial;
            end
        endcase

        // Abort overrides everything, including a pending store.
        if (parar) begin
            estado_d    = Inicial;
            cnt_d       = '0;
            posicao_d   = '0;
            sobe_d      = 1'b1;
            pronto_d    = 1'b0;
            guarda      = 1'b0;
            guarda_erro = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= Inicial;
            cnt_q        <= '0;
            sub_q        <= '0;
            cm_q         <= '0;
            posicao_q    <= '0;
            sobe_q       <= 1'b1;
            pronto_q     <= 1'b0;
            iniciar_q    <= 1'b0;
            medida_q     <= '0;
            medida_pos_q <= '0;
            erro_q       <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            posicao_q <= posicao_d;
            sobe_q    <= sobe_d;
            pronto_q  <= pronto_d;
            iniciar_q <= iniciar;
            if (guarda) begin
                medida_q     <= guarda_erro ? CmMax : medida_arred;
                erro_q       <= guarda_erro;
                medida_pos_q <= posicao_q;
            end
        end
    end

    assign trigger       = (estado_q == Dispara);
    assign medida_valida = (estado_q == Armazena);
    assign posicao       = posicao_q;
    assign medida        = medida_q;
    assign medida_pos    = medida_pos_q;
    assign erro          = erro_q;
    assign pronto        = pronto_q;
    assign db_estado     = estado_q;

endmodule
